// File: rtl/final_perm_serializer_pkg.sv
// Shared DES constants: block/count widths, final-permutation index table and serializer states.
package final_perm_serializer_pkg;

  localparam int BLK_W = 64;
  localparam int CNT_W = 3;
  localparam logic [CNT_W-1:0] CNT_LAST = 3'd7;

  // fp[i] = blk[FP_IDX[i]]; FP_IDX[i] is where the initial permutation sends input bit i
  localparam int FP_IDX [0:BLK_W-1] = '{
    39,  7, 47, 15, 55, 23, 63, 31,
    38,  6, 46, 14, 54, 22, 62, 30,
    37,  5, 45, 13, 53, 21, 61, 29,
    36,  4, 44, 12, 52, 20, 60, 28,
    35,  3, 43, 11, 51, 19, 59, 27,
    34,  2, 42, 10, 50, 18, 58, 26,
    33,  1, 41,  9, 49, 17, 57, 25,
    32,  0, 40,  8, 48, 16, 56, 24
  };

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/final_perm_serializer_if.sv
// Block-in / byte-out handshake bundle of the final-permutation serializer.
interface final_perm_serializer_if;
  import final_perm_serializer_pkg::*;

  logic             blk_valid;
  logic             blk_ready;
  logic [BLK_W-1:0] blk_data;
  logic             byte_valid;
  logic             byte_ready;
  logic [7:0]       byte_data;
  logic             byte_last;
  logic             busy;

  modport master (
    output blk_valid, blk_data, byte_ready,
    input  blk_ready, byte_valid, byte_data, byte_last, busy
  );

  modport slave (
    input  blk_valid, blk_data, byte_ready,
    output blk_ready, byte_valid, byte_data, byte_last, busy
  );

endinterface

// File: rtl/final_perm_serializer_des_final_perm.sv
// Purely combinational DES inverse initial permutation, shared with the decrypt path.
module des_final_perm
  import final_perm_serializer_pkg::*;
(
  input  logic [BLK_W-1:0] blk,
  output logic [BLK_W-1:0] fp
);

  for (genvar i = 0; i < BLK_W; i++) begin : g_bit
    assign fp[i] = blk[FP_IDX[i]];
  end

endmodule

// File: rtl/final_perm_serializer.sv
// Applies the DES final permutation to each 64-bit block and streams it out as 8 bytes,
// with one pending block buffered so back-to-back blocks produce bytes without a bubble.
module final_perm_serializer
  import final_perm_serializer_pkg::*;
#(
  parameter int BYTE_MSB_FIRST = 1
) (
  input logic                    clk,
  input logic                    rst_n,
  final_perm_serializer_if.slave bus
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BLK_W-1:0] shift_q, shift_d;
  logic [BLK_W-1:0] pend_q, pend_d;
  logic             pend_full_q, pend_full_d;
  logic [BLK_W-1:0] fp;
  logic [BLK_W-1:0] shifted;
  logic             blk_xfer;
  logic             byte_xfer;
  logic             last_byte;

  des_final_perm u_fp (
    .blk (bus.blk_data),
    .fp  (fp)
  );

  // The outgoing byte always sits at the emitting end of the shifter
  assign shifted   = (BYTE_MSB_FIRST != 0) ? {shift_q[BLK_W-9:0], 8'h00}
                                           : {8'h00, shift_q[BLK_W-1:8]};
  assign blk_xfer  = bus.blk_valid && !pend_full_q;
  assign byte_xfer = (state_q == ST_SHIFT) && bus.byte_ready;
  assign last_byte = (cnt_q == CNT_LAST);

  assign bus.blk_ready  = !pend_full_q;
  assign bus.byte_valid = (state_q == ST_SHIFT);
  assign bus.byte_last  = (state_q == ST_SHIFT) && last_byte;
  assign bus.byte_data  = (BYTE_MSB_FIRST != 0) ? shift_q[BLK_W-1 -: 8] : shift_q[7:0];
  assign bus.busy       = (state_q == ST_SHIFT) || pend_full_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    case (state_q)
      ST_IDLE: begin
        if (blk_xfer) begin
          shift_d = fp;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (byte_xfer) begin
          if (!last_byte) begin
            cnt_d   = cnt_q + 1'b1;
            shift_d = shifted;
          end else if (pend_full_q) begin
            shift_d     = pend_q;
            cnt_d       = '0;
            pend_full_d = 1'b0;
          end else if (blk_xfer) begin
            shift_d = fp;
            cnt_d   = '0;
          end else begin
            shift_d = shifted;
            state_d = ST_IDLE;
          end
        end
        // A block arriving on the final byte goes straight to the shifter instead
        if (blk_xfer && !(byte_xfer && last_byte)) begin
          pend_d      = fp;
          pend_full_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule
